// File: rtl/cv32e40p_mult_ft_scanner.sv
// rtl/cv32e40p_mult_ft_scanner.sv - scans MULT FT error counters and faulty map over the FT CSR port
// Streams one record per counter plus the map, optionally clearing each counter after it is read.
module cv32e40p_mult_ft_scanner #(
  parameter logic [11:0] CNT_BASE_ADDR = 12'hBE0,  // CSR_MHPMCOUNTERM0_FT
  parameter logic [11:0] MAP_ADDR      = 12'hBF0,  // CSR_PERM_FAULTY_MULT_FT
  parameter logic [31:0] WARN_LEVEL    = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        clear_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        csr_grant_i,
  output logic [11:0] mhpm_addr_o,
  output logic        mhpm_re_o,
  output logic        mhpm_we_o,
  output logic [31:0] mhpm_wdata_o,
  input  logic [31:0] mhpm_rdata_i,
  output logic        rec_valid_o,
  input  logic        rec_ready_i,
  output logic [3:0]  rec_idx_o,
  output logic [31:0] rec_data_o,
  output logic        rec_warn_o,
  output logic [11:0] warn_map_o,
  output logic [11:0] faulty_map_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EMIT, S_CLR, S_DONE} state_t;

  localparam logic [3:0] MAP_IDX = 4'd12;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        clr_q, clr_d;
  logic [31:0] rec_data_q, rec_data_d;
  logic        rec_warn_q, rec_warn_d;
  logic [11:0] warn_map_q, warn_map_d;
  logic [11:0] faulty_map_q, faulty_map_d;
  logic [11:0] cnt_addr;
  logic        rd_warn;

  assign cnt_addr = CNT_BASE_ADDR + {8'd0, idx_q};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    clr_d        = clr_q;
    rec_data_d   = rec_data_q;
    rec_warn_d   = rec_warn_q;
    warn_map_d   = warn_map_q;
    faulty_map_d = faulty_map_q;
    mhpm_addr_o  = '0;
    mhpm_re_o    = 1'b0;
    mhpm_we_o    = 1'b0;
    mhpm_wdata_o = '0;
    // The map record warns on any faulty unit; counters warn on level
    rd_warn = (idx_q == MAP_IDX) ? (|mhpm_rdata_i[11:0]) : (mhpm_rdata_i >= WARN_LEVEL);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d      = '0;
          clr_d      = clear_i;
          warn_map_d = '0;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        mhpm_addr_o = (idx_q == MAP_IDX) ? MAP_ADDR : cnt_addr;
        mhpm_re_o   = csr_grant_i;
        if (csr_grant_i) begin
          rec_data_d = mhpm_rdata_i;
          rec_warn_d = rd_warn;
          if (idx_q == MAP_IDX) begin
            faulty_map_d = mhpm_rdata_i[11:0];
          end else begin
            warn_map_d[idx_q] = warn_map_q[idx_q] | rd_warn;
          end
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rec_ready_i) begin
          if (idx_q == MAP_IDX) begin
            state_d = S_DONE;
          end else if (clr_q) begin
            state_d = S_CLR;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_RD;
          end
        end
      end
      S_CLR: begin
        mhpm_addr_o = cnt_addr;
        mhpm_we_o   = csr_grant_i;
        if (csr_grant_i) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      clr_q        <= 1'b0;
      rec_data_q   <= '0;
      rec_warn_q   <= 1'b0;
      warn_map_q   <= '0;
      faulty_map_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      clr_q        <= clr_d;
      rec_data_q   <= rec_data_d;
      rec_warn_q   <= rec_warn_d;
      warn_map_q   <= warn_map_d;
      faulty_map_q <= faulty_map_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign rec_valid_o  = (state_q == S_EMIT);
  assign rec_idx_o    = rec_valid_o ? idx_q : 4'd0;
  assign rec_data_o   = rec_valid_o ? rec_data_q : 32'd0;
  assign rec_warn_o   = rec_valid_o & rec_warn_q;
  assign warn_map_o   = warn_map_q;
  assign faulty_map_o = faulty_map_q;

endmodule

// File: tb/tb_cv32e40p_mult_ft_scanner.sv
// tb/tb_cv32e40p_mult_ft_scanner.sv - self-checking bench for cv32e40p_mult_ft_scanner
// Bench owns a CSR responder holding the 12 counters and the faulty map.
module tb_cv32e40p_mult_ft_scanner;

  localparam logic [11:0] BASE = 12'hBE0;
  localparam logic [11:0] MAPA = 12'hBF0;

  logic        clk = 1'b0;
  logic        rst, start_i, clear_i, busy_o, done_o, csr_grant_i;
  logic [11:0] mhpm_addr_o;
  logic        mhpm_re_o, mhpm_we_o;
  logic [31:0] mhpm_wdata_o, mhpm_rdata_i, rd_val;
  logic        rec_valid_o, rec_ready_i, rec_warn_o;
  logic [3:0]  rec_idx_o;
  logic [31:0] rec_data_o;
  logic [11:0] warn_map_o, faulty_map_o;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          last_hs_idx = 0;
  logic [31:0] mem [12];
  logic [31:0] m_cnt [12];
  logic [31:0] map_reg;

  typedef struct {
    bit          clr;
    int          mode;
    logic [31:0] map;
    int          rstall;
    int          g7;
    int          g2;
    int          done;
    logic [11:0] warn;
    logic [11:0] faulty;
  } vec_t;
  vec_t tbl [7];

  cv32e40p_mult_ft_scanner #(
    .CNT_BASE_ADDR(BASE),
    .MAP_ADDR     (MAPA),
    .WARN_LEVEL   (32'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .clear_i     (clear_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .csr_grant_i (csr_grant_i),
    .mhpm_addr_o (mhpm_addr_o),
    .mhpm_re_o   (mhpm_re_o),
    .mhpm_we_o   (mhpm_we_o),
    .mhpm_wdata_o(mhpm_wdata_o),
    .mhpm_rdata_i(mhpm_rdata_i),
    .rec_valid_o (rec_valid_o),
    .rec_ready_i (rec_ready_i),
    .rec_idx_o   (rec_idx_o),
    .rec_data_o  (rec_data_o),
    .rec_warn_o  (rec_warn_o),
    .warn_map_o  (warn_map_o),
    .faulty_map_o(faulty_map_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    int off;
    off    = int'(mhpm_addr_o) - int'(BASE);
    rd_val = 32'hDEAD_BEEF;
    if (mhpm_addr_o == MAPA) rd_val = map_reg;
    else if (off >= 0 && off < 12) rd_val = mem[off];
  end

  // Garbage unless strobed, so an ungranted capture corrupts the record
  assign mhpm_rdata_i = mhpm_re_o ? rd_val : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mhpm_we_o === 1'b1) begin
      int off;
      off = int'(mhpm_addr_o) - int'(BASE);
      chk("wr_addr", {20'd0, mhpm_addr_o}, 32'(BASE) + 32'(last_hs_idx));
      chk("wr_data", mhpm_wdata_o, 32'd0);
      n_writes++;
      if (off >= 0 && off < 12) mem[off] = 32'd0;
    end
  end

  task automatic preset(input int mode, input logic [31:0] map);
    map_reg = map;
    for (int k = 0; k < 12; k++) begin
      case (mode)
        0:       m_cnt[k] = 32'(k + 100);
        1:       m_cnt[k] = 32'(k);
        2:       m_cnt[k] = (k == 5) ? 32'd8 : ((k == 6) ? 32'd7 : 32'd0);
        3:       m_cnt[k] = 32'd0;
        default: m_cnt[k] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 16)) : $urandom;
      endcase
      if (mode != 3) mem[k] = m_cnt[k];
    end
  endtask

  task automatic run_scan(input bit clr, input logic [31:0] map, input int rstall, input int g7,
                          input int g2, input int exp_done, input logic [11:0] exp_warn,
                          input logic [11:0] exp_faulty, input bit rnd);
    logic [31:0] e_data [13];
    logic        e_warn [13];
    logic [11:0] a, prev_a;
    int pos, cyc, r_left, g7_left, g2_left, app7, app2, done_cyc;
    bit fin;
    for (int k = 0; k < 12; k++) begin
      e_data[k] = m_cnt[k];
      e_warn[k] = (m_cnt[k] >= 32'd8);
    end
    e_data[12] = map;
    e_warn[12] = (map[11:0] != 12'd0);
    r_left = rstall; g7_left = g7; g2_left = g2;
    pos = 0; app7 = 0; app2 = 0; done_cyc = -1; fin = 0; prev_a = '0; n_writes = 0;

    @(negedge clk);
    start_i = 1'b1; clear_i = clr; csr_grant_i = 1'b1; rec_ready_i = 1'b1;
    @(negedge clk);
    clear_i = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!fin && cyc < 400) begin
      a = mhpm_addr_o;
      if (a != prev_a && a == BASE + 12'd7) app7++;
      if (a != prev_a && a == BASE + 12'd2) app2++;
      prev_a = a;
      csr_grant_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (a == BASE + 12'd7 && app7 == 1 && g7_left > 0) begin csr_grant_i = 1'b0; g7_left--; end
      if (a == BASE + 12'd2 && app2 == 2 && g2_left > 0) begin csr_grant_i = 1'b0; g2_left--; end
      rec_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rec_valid_o && rec_idx_o == 4'd3 && r_left > 0) begin rec_ready_i = 1'b0; r_left--; end
      start_i = ($urandom_range(0, 3) == 0);
      #1;
      chk("busy_in_scan", busy_o, 1'b1);
      if (!csr_grant_i) chk("strobe_no_grant", {mhpm_re_o, mhpm_we_o}, 2'b00);
      chk("re_we_excl", mhpm_re_o & mhpm_we_o, 1'b0);
      if (rec_valid_o) begin
        chk("strobe_in_emit", mhpm_re_o | mhpm_we_o, 1'b0);
        if (pos < 13) begin
          chk("rec_idx", rec_idx_o, pos);
          chk("rec_data", rec_data_o, e_data[pos]);
          chk("rec_warn", rec_warn_o, e_warn[pos]);
        end else begin
          chk("extra_record", pos, 13 - 1);
        end
        if (rec_ready_i) begin last_hs_idx = pos; pos++; end
      end
      if (done_o) begin done_cyc = cyc; fin = 1; end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    chk("done_seen", fin, 1'b1);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    chk("rec_count", pos, 13);
    #1;
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_done", done_o, 1'b0);
    chk("idle_valid", rec_valid_o, 1'b0);
    chk("warn_map", warn_map_o, exp_warn);
    chk("faulty_map", faulty_map_o, exp_faulty);
    for (int k = 0; k < 12; k++) chk("counter_after", mem[k], clr ? 32'd0 : m_cnt[k]);
    chk("write_count", n_writes, clr ? 12 : 0);
  endtask

  initial begin
    logic [11:0] ew;
    bit found;
    int hs;
    tbl[0] = '{1'b0, 0, 32'h0000_0000, 0, 0, 0, 27, 12'hFFF, 12'h000};
    tbl[1] = '{1'b1, 0, 32'h0000_0000, 0, 0, 0, 39, 12'hFFF, 12'h000};
    tbl[2] = '{1'b0, 3, 32'h0000_0000, 0, 0, 0, 27, 12'h000, 12'h000};
    tbl[3] = '{1'b0, 2, 32'h0000_0020, 0, 0, 0, 27, 12'h020, 12'h020};
    tbl[4] = '{1'b0, 2, 32'hFFFF_F000, 0, 0, 0, 27, 12'h020, 12'h000};
    tbl[5] = '{1'b0, 1, 32'h0000_0801, 5, 0, 0, 32, 12'hF00, 12'h801};
    tbl[6] = '{1'b1, 1, 32'h0000_0FFF, 5, 4, 3, 51, 12'hF00, 12'hFFF};

    rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; csr_grant_i = 1'b0; rec_ready_i = 1'b0;
    map_reg = '0;
    for (int k = 0; k < 12; k++) begin mem[k] = '0; m_cnt[k] = '0; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_addr", mhpm_addr_o, 12'd0);
    chk("rst_strobes", {mhpm_re_o, mhpm_we_o}, 2'b00);
    chk("rst_wdata", mhpm_wdata_o, 32'd0);
    chk("rst_rec", {rec_valid_o, rec_warn_o, rec_idx_o}, 6'd0);
    chk("rst_rec_data", rec_data_o, 32'd0);
    chk("rst_maps", {warn_map_o, faulty_map_o}, 24'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      preset(tbl[i].mode, tbl[i].map);
      run_scan(tbl[i].clr, tbl[i].map, tbl[i].rstall, tbl[i].g7, tbl[i].g2,
               tbl[i].done, tbl[i].warn, tbl[i].faulty, 1'b0);
    end

    // Reset in the CLR cycle of idx 4, with stray starts while busy
    preset(0, 32'h0);
    @(negedge clk);
    start_i = 1'b1; clear_i = 1'b1; csr_grant_i = 1'b1; rec_ready_i = 1'b1;
    @(negedge clk);
    found = 0; hs = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      start_i = 1'($urandom_range(0, 1));
      #1;
      if (rec_valid_o && rec_ready_i) begin last_hs_idx = hs; hs++; end
      if (mhpm_we_o && mhpm_addr_o == BASE + 12'd4) found = 1;
      else @(negedge clk);
    end
    chk("reach_clr4", found, 1'b1);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_bus", {mhpm_addr_o, mhpm_re_o, mhpm_we_o}, 14'd0);
    chk("mid_rst_rec", {rec_valid_o, rec_warn_o, rec_idx_o}, 6'd0);
    chk("mid_rst_rec_data", rec_data_o, 32'd0);
    chk("mid_rst_warn_map", warn_map_o, 12'd0);
    chk("mid_rst_faulty_map", faulty_map_o, 12'd0);
    chk("mid_rst_clr4_committed", mem[4], 32'd0);

    preset(tbl[3].mode, tbl[3].map);
    run_scan(1'b0, tbl[3].map, 0, 0, 0, 27, 12'h020, 12'h020, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [31:0] mp;
      bit cl;
      mp = $urandom;
      cl = 1'($urandom_range(0, 1));
      preset(4, mp);
      for (int k = 0; k < 12; k++) ew[k] = (m_cnt[k] >= 32'd8);
      run_scan(cl, mp, 0, 0, 0, -1, ew, mp[11:0], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
